// File: rtl/bt656_rx.sv
// BT.656 embedded-sync receiver: finds FF 00 00 XY codes, recovers F/V/H, tracks lines and lock.
// Define BT656_RX_ECC_EN to correct single-bit XY errors (adds the o_EccCorr port).
module bt656_rx #(
  parameter int HACT_BYTES = 22,
  parameter int LOCK_LINES = 2,
  parameter int MAX_LINES  = 1023
) (
  input  logic                             PixelClock,
  input  logic                             i_ResetN,
  input  logic [7:0]                       i_Data,
  output logic [7:0]                       o_Data,
  output logic                             o_DataValid,
  output logic                             o_F,
  output logic                             o_V,
  output logic                             o_H,
  output logic                             o_SavPulse,
  output logic                             o_EavPulse,
  output logic [$clog2(HACT_BYTES+1)-1:0]  o_PixelCount,
  output logic [$clog2(MAX_LINES+1)-1:0]   o_LineCount,
  output logic                             o_Locked,
  output logic                             o_SyncErr
`ifdef BT656_RX_ECC_EN
  ,
  output logic                             o_EccCorr
`endif
);

  localparam int PW = $clog2(HACT_BYTES+1);
  localparam int LW = $clog2(MAX_LINES+1);
  localparam int AW = $clog2(HACT_BYTES+5);
  localparam int KW = $clog2(LOCK_LINES+1);
  // Input-side count includes the FF 00 00 of the closing EAV preamble.
  localparam logic [AW-1:0] LEN_OK  = AW'(HACT_BYTES+3);
  localparam logic [AW-1:0] LEN_MAX = AW'(HACT_BYTES+4);

  typedef enum logic [1:0] {SEEK, GOT_FF, GOT_00, GOT_0000} state_t;

  state_t          r_State, w_NextState;
  logic [3:0][7:0] r_Dly;
  logic [3:0]      r_Vld;
  logic            r_Window, r_HaveCode;
  logic            r_F, r_V, r_H, r_SavPulse, r_EavPulse, r_SyncErr, r_Locked;
  logic [AW-1:0]   r_ActCount;
  logic [PW-1:0]   r_PixelCount;
  logic [LW-1:0]   r_LineCount;
  logic [KW-1:0]   r_GoodCnt, w_GoodNext;
  logic            w_F, w_V, w_H, w_XyOk;
  logic [3:0]      w_Syn;
  logic            w_IsXy, w_Accept, w_OrderErr, w_LenErr, w_Err, w_GoodEav;
`ifdef BT656_RX_ECC_EN
  logic            w_Corr;
  logic            r_EccCorr;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_NextState = SEEK;
    unique case (r_State)
      SEEK:     if (i_Data == 8'hFF) w_NextState = GOT_FF;
      GOT_FF:   if (i_Data == 8'h00) w_NextState = GOT_00;
                else if (i_Data == 8'hFF) w_NextState = GOT_FF;
      GOT_00:   if (i_Data == 8'h00) w_NextState = GOT_0000;
                else if (i_Data == 8'hFF) w_NextState = GOT_FF;
      GOT_0000: w_NextState = SEEK;
      default:  w_NextState = SEEK;
    endcase
  end

  always_comb begin
    w_F   = i_Data[6];
    w_V   = i_Data[5];
    w_H   = i_Data[4];
    w_Syn = i_Data[3:0] ^ {i_Data[5] ^ i_Data[4], i_Data[6] ^ i_Data[4],
                           i_Data[6] ^ i_Data[5], i_Data[6] ^ i_Data[5] ^ i_Data[4]};
`ifdef BT656_RX_ECC_EN
    w_XyOk = i_Data[7];
    w_Corr = 1'b0;
    // Each data bit flips a distinct three-bit parity pattern; a lone parity bit flips one.
    case (w_Syn)
      4'b0000: ;
      4'b0111: begin w_F = ~i_Data[6]; w_Corr = 1'b1; end
      4'b1011: begin w_V = ~i_Data[5]; w_Corr = 1'b1; end
      4'b1101: begin w_H = ~i_Data[4]; w_Corr = 1'b1; end
      4'b1000, 4'b0100, 4'b0010, 4'b0001: w_Corr = 1'b1;
      default: w_XyOk = 1'b0;
    endcase
`else
    w_XyOk = i_Data[7] && (w_Syn == 4'b0000);
`endif
  end

  assign w_IsXy     = (r_State == GOT_0000);
  assign w_Accept   = w_IsXy && w_XyOk;
  assign w_OrderErr = w_Accept && r_HaveCode && (w_H == r_H);
  assign w_LenErr   = w_Accept && w_H && r_Window && (r_ActCount != LEN_OK);
  assign w_Err      = (w_IsXy && !w_XyOk) || w_OrderErr || w_LenErr;
  assign w_GoodEav  = w_Accept && w_H && r_HaveCode && !w_Err;

  always_comb begin
    w_GoodNext = r_GoodCnt;
    if (w_Err) w_GoodNext = '0;
    else if (w_GoodEav && (r_GoodCnt != KW'(LOCK_LINES))) w_GoodNext = r_GoodCnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge PixelClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_State      <= SEEK;
      // NOTE: the delay line is reset too, since o_Data must read 0 straight out of reset.
      r_Dly        <= '0;
      r_Vld        <= '0;
      r_Window     <= 1'b0;
      r_HaveCode   <= 1'b0;
      r_F          <= 1'b0;
      r_V          <= 1'b0;
      r_H          <= 1'b0;
      r_SavPulse   <= 1'b0;
      r_EavPulse   <= 1'b0;
      r_SyncErr    <= 1'b0;
      r_Locked     <= 1'b0;
      r_ActCount   <= '0;
      r_PixelCount <= '0;
      r_LineCount  <= '0;
      r_GoodCnt    <= '0;
`ifdef BT656_RX_ECC_EN
      r_EccCorr    <= 1'b0;
`endif
    end else begin
      r_State    <= w_NextState;
      r_Dly      <= {r_Dly[2:0], i_Data};
      // On XY the whole pipeline holds FF 00 00 XY, so all four flags are masked together.
      r_Vld      <= w_IsXy ? 4'b0000 : {r_Vld[2:0], r_Window};
      r_SavPulse <= w_Accept && !w_H;
      r_EavPulse <= w_Accept && w_H;
      r_SyncErr  <= w_Err;
      r_GoodCnt  <= w_GoodNext;
      r_Locked   <= (w_GoodNext == KW'(LOCK_LINES));
`ifdef BT656_RX_ECC_EN
      r_EccCorr  <= w_Accept && w_Corr;
`endif
      if (w_IsXy) r_Window <= w_Accept && !w_H && !w_V;
      if (w_Accept) begin
        r_F        <= w_F;
        r_V        <= w_V;
        r_H        <= w_H;
        r_HaveCode <= 1'b1;
      end
      if (w_Accept && !w_H) r_ActCount <= '0;
      else if (r_Window && !w_IsXy && (r_ActCount != LEN_MAX)) r_ActCount <= r_ActCount + 1'b1;
      if (w_Accept && !w_H) r_PixelCount <= '0;
      else if (r_Vld[3] && (r_PixelCount != PW'(HACT_BYTES))) r_PixelCount <= r_PixelCount + 1'b1;
      if (w_Accept && w_H) begin
        if (w_F != r_F) r_LineCount <= '0;
        else if (r_LineCount != LW'(MAX_LINES)) r_LineCount <= r_LineCount + 1'b1;
      end
    end
  end

  assign o_Data       = r_Dly[3];
  assign o_DataValid  = r_Vld[3] && r_Locked;
  assign o_F          = r_F;
  assign o_V          = r_V;
  assign o_H          = r_H;
  assign o_SavPulse   = r_SavPulse;
  assign o_EavPulse   = r_EavPulse;
  assign o_PixelCount = r_PixelCount;
  assign o_LineCount  = r_LineCount;
  assign o_Locked     = r_Locked;
  assign o_SyncErr    = r_SyncErr;
`ifdef BT656_RX_ECC_EN
  assign o_EccCorr    = r_EccCorr;
`endif

endmodule

// File: tb/tb_bt656_rx.sv
// Scoreboard bench for bt656_rx: the driver queues expected code events and data bytes,
// a negedge monitor pops and compares whenever the receiver reports something.
module tb_bt656_rx;
`ifdef BT656_RX_ECC_EN
  localparam bit ECC = 1'b1;
`else
  localparam bit ECC = 1'b0;
`endif

  logic       PixelClock = 1'b0;
  logic       i_ResetN   = 1'b0;
  logic [7:0] i_Data     = 8'h80;
  logic [7:0] o_Data;
  logic       o_DataValid, o_F, o_V, o_H, o_SavPulse, o_EavPulse, o_Locked, o_SyncErr, o_EccCorr;
  logic [4:0] o_PixelCount;
  logic [9:0] o_LineCount;

  bt656_rx dut (
    .PixelClock  (PixelClock),
    .i_ResetN    (i_ResetN),
    .i_Data      (i_Data),
    .o_Data      (o_Data),
    .o_DataValid (o_DataValid),
    .o_F         (o_F),
    .o_V         (o_V),
    .o_H         (o_H),
    .o_SavPulse  (o_SavPulse),
    .o_EavPulse  (o_EavPulse),
    .o_PixelCount(o_PixelCount),
    .o_LineCount (o_LineCount),
    .o_Locked    (o_Locked),
    .o_SyncErr   (o_SyncErr)
`ifdef BT656_RX_ECC_EN
    ,
    .o_EccCorr   (o_EccCorr)
`endif
  );
`ifndef BT656_RX_ECC_EN
  assign o_EccCorr = 1'b0;
`endif

  always #5 PixelClock = ~PixelClock;

  typedef struct packed {
    logic       sav, eav, err, ecc, f, v, h, lock;
    logic [9:0] lc;
  } ev_t;
  typedef struct packed {
    logic [7:0] d;
    logic [4:0] idx;
  } dv_t;

  ev_t evq[$];
  dv_t dq[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  function automatic ev_t mk(input bit sav, input bit eav, input bit err, input bit ecc,
                             input bit f, input bit v, input bit h, input bit lock, input int lc);
    ev_t e;
    e = '{sav: sav, eav: eav, err: err, ecc: ecc, f: f, v: v, h: h, lock: lock, lc: 10'(lc)};
    return e;
  endfunction

  function automatic logic [31:0] out_vec();
    return {1'b0, o_Data, o_DataValid, o_F, o_V, o_H, o_SavPulse, o_EavPulse,
            o_Locked, o_SyncErr, o_PixelCount, o_LineCount};
  endfunction

  // Monitor: compares only when the receiver presents a data byte or a code event.
  always @(negedge PixelClock) begin
    if (i_ResetN) begin
      if (o_DataValid) begin
        if (dq.size() == 0) unexpected("data_valid", {19'd0, o_Data, o_PixelCount});
        else begin
          dv_t x;
          x = dq.pop_front();
          check("data_byte", {19'd0, o_Data, o_PixelCount}, {19'd0, x});
        end
      end
      if (o_SavPulse || o_EavPulse || o_SyncErr || o_EccCorr) begin
        ev_t a;
        a = '{sav: o_SavPulse, eav: o_EavPulse, err: o_SyncErr, ecc: o_EccCorr,
              f: o_F, v: o_V, h: o_H, lock: o_Locked, lc: o_LineCount};
        if (evq.size() == 0) unexpected("code_event", {14'd0, a});
        else begin
          ev_t x;
          x = evq.pop_front();
          check("code_event", {14'd0, a}, {14'd0, x});
        end
      end
    end
  end

  task automatic put(input logic [7:0] b);
    @(posedge PixelClock);
    #1 i_Data = b;
  endtask

  task automatic code(input logic [7:0] xy, input ev_t e);
    put(8'hFF); put(8'h00); put(8'h00); put(xy);
    evq.push_back(e);
  endtask

  task automatic active(input int n, input bit vld);
    for (int i = 0; i < n; i++) begin
      put(8'(8'h10 + i));
      if (vld) dq.push_back('{d: 8'(8'h10 + i), idx: 5'(i)});
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) put(8'h80);
  endtask

  task automatic line(input int n, input bit vld, input bit lk_s, input int lc_s,
                      input bit lk_e, input bit err_e, input int lc_e);
    code(8'h80, mk(1, 0, 0, 0, 0, 0, 0, lk_s, lc_s));
    active(n, vld);
    code(8'h9D, mk(0, 1, err_e, 0, 0, 0, 1, lk_e, lc_e));
    blank(12);
  endtask

  initial begin
    repeat (3) @(posedge PixelClock);
    #1 check("reset_state", out_vec(), 32'd0);
    @(negedge PixelClock) i_ResetN = 1'b1;
    blank(8);

    // Acquisition: lock after the second good EAV, third line delivers its data.
    line(22, 0, 0, 0, 0, 0, 1);
    line(22, 0, 0, 1, 1, 0, 2);
    line(22, 1, 1, 2, 1, 0, 3);

    // Short line: length error at EAV, next line unqualified, then relock.
    line(21, 1, 1, 3, 0, 1, 4);
    line(22, 0, 0, 4, 0, 0, 5);
    line(22, 0, 0, 5, 1, 0, 6);

    // SAV with P0 flipped: corrected with ECC, otherwise an error followed by an out-of-order EAV.
    code(8'h81, ECC ? mk(1, 0, 0, 1, 0, 0, 0, 1, 6) : mk(0, 0, 1, 0, 0, 0, 1, 0, 6));
    active(22, ECC);
    code(8'h9D, mk(0, 1, !ECC, 0, 0, 0, 1, ECC, 7));
    blank(12);
    line(22, ECC, ECC, 7, ECC, 0, 8);
    line(22, ECC, ECC, 8, 1, 0, 9);

    // Vertical blanking, field 0 then field 1: line counter clears on the F change.
    code(8'hAB, mk(1, 0, 0, 0, 0, 1, 0, 1, 9));
    blank(22);
    code(8'hB6, mk(0, 1, 0, 0, 0, 1, 1, 1, 10));
    blank(12);
    code(8'hAB, mk(1, 0, 0, 0, 0, 1, 0, 1, 10));
    blank(22);
    code(8'hF1, mk(0, 1, 0, 0, 1, 1, 1, 1, 0));
    blank(12);
    code(8'hEC, mk(1, 0, 0, 0, 1, 1, 0, 1, 0));
    blank(22);
    code(8'hF1, mk(0, 1, 0, 0, 1, 1, 1, 1, 1));
    blank(12);

    // Two SAVs in a row: second one is an ordering error but still opens the line.
    code(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    active(5, 1);
    code(8'h80, mk(1, 0, 1, 0, 0, 0, 0, 0, 1));
    active(22, 0);
    code(8'h9D, mk(0, 1, 0, 0, 0, 0, 1, 0, 2));
    blank(12);
    line(22, 0, 0, 2, 1, 0, 3);

    // Reset in the middle of an active line, after byte 9 has been shown.
    code(8'h80, mk(1, 0, 0, 0, 0, 0, 0, 1, 3));
    active(10, 1);
    repeat (5) @(posedge PixelClock);
    #2 i_ResetN = 1'b0;
    #1 check("mid_line_reset", out_vec(), 32'd0);
    i_Data = 8'h80;
    repeat (3) @(negedge PixelClock);
    check("reset_hold", out_vec(), 32'd0);
    i_ResetN = 1'b1;
    blank(6);
    line(22, 0, 0, 0, 0, 0, 1);
    line(22, 0, 0, 1, 1, 0, 2);
    line(22, 1, 1, 2, 1, 0, 3);
    blank(10);

    check("data_queue_drained", 32'(dq.size()), 32'd0);
    check("event_queue_drained", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
